// File: rtl/conv_frame_sink_if.sv
// Pixel stream from conv_frame_sink to the next stage: data plus sof/eol/eof markers.
// m_valid/m_ready: a pixel transfers on a rising edge where both are high; once m_valid rises, m_data and markers hold until that edge.
interface conv_frame_sink_if #(
    parameter int DW = 12
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;

    modport master (
        output m_data, m_valid, m_sof, m_eol, m_eof,
        input  m_ready
    );

    modport slave (
        input  m_data, m_valid, m_sof, m_eol, m_eof,
        output m_ready
    );
endinterface

// File: rtl/conv_frame_sink.sv
// Captures conv2d result writes into a frame buffer, then replays the frame in raster
// order as a marked valid/ready pixel stream once conv2d signals completion.
module conv_frame_sink #(
    parameter int IMG_W = 50,
    parameter int IMG_H = 50,
    parameter int DW    = 12,
    parameter int AW    = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              conv_done,
    conv_frame_sink_if.master m,
    output logic              busy,
    output logic              frame_done,
    output logic              err_oob,
    output logic              err_ovr,
    output logic              state_dbg
);
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int MAW   = $clog2(TOTAL);
    localparam int IW    = $clog2(TOTAL + 1);
    localparam int XW    = $clog2(IMG_W + 1);
    localparam int YW    = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic {COLLECT = 1'b0, STREAM = 1'b1} state_t;

    state_t        state;
    logic          conv_done_q;
    logic [DW-1:0] mem [TOTAL];
    logic [DW-1:0] rd_q;
    logic [IW-1:0] rd_idx;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          s1_v, s1_sof, s1_eol, s1_eof;

    logic done_rise, wr_in_range, write_ok;
    logic s2_load, s1_adv, rd_issue;

    assign state_dbg   = state;
    assign done_rise   = conv_done & ~conv_done_q;
    assign wr_in_range = wr_addr < AW'(TOTAL);
    assign write_ok    = (state == COLLECT) && wr_en && wr_in_range;

    // Two-stage read pipeline (RAM output register, then output register) with
    // ready chained back to the read enable: stalls freeze both stages, no bubbles.
    assign s2_load  = !m.m_valid || m.m_ready;
    assign s1_adv   = !s1_v || s2_load;
    assign rd_issue = (state == STREAM) && (rd_idx != IW'(TOTAL)) && s1_adv;

    always_ff @(posedge clk) begin
        if (write_ok) mem[wr_addr[MAW-1:0]] <= wr_data;
        if (rd_issue) rd_q <= mem[rd_idx[MAW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= COLLECT;
            conv_done_q <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_oob     <= 1'b0;
            err_ovr     <= 1'b0;
            rd_idx      <= '0;
            rd_x        <= '0;
            rd_y        <= '0;
            s1_v        <= 1'b0;
            s1_sof      <= 1'b0;
            s1_eol      <= 1'b0;
            s1_eof      <= 1'b0;
            m.m_valid   <= 1'b0;
            m.m_data    <= '0;
            m.m_sof     <= 1'b0;
            m.m_eol     <= 1'b0;
            m.m_eof     <= 1'b0;
        end else begin
            conv_done_q <= conv_done;
            frame_done  <= 1'b0;
            case (state)
                COLLECT: begin
                    if (wr_en && !wr_in_range) err_oob <= 1'b1;
                    if (done_rise) begin
                        state  <= STREAM;
                        busy   <= 1'b1;
                        rd_idx <= '0;
                        rd_x   <= '0;
                        rd_y   <= '0;
                        s1_v   <= 1'b0;
                    end
                end
                STREAM: begin
                    if (wr_en) err_ovr <= 1'b1;
                    if (rd_issue) begin
                        rd_idx <= rd_idx + 1'b1;
                        s1_sof <= (rd_x == '0) && (rd_y == '0);
                        s1_eol <= (rd_x == X_LAST);
                        s1_eof <= (rd_x == X_LAST) && (rd_y == Y_LAST);
                        if (rd_x == X_LAST) begin
                            rd_x <= '0;
                            rd_y <= rd_y + 1'b1;
                        end else begin
                            rd_x <= rd_x + 1'b1;
                        end
                    end
                    if (s1_adv) s1_v <= rd_issue;
                    if (s2_load) begin
                        m.m_valid <= s1_v;
                        if (s1_v) begin
                            m.m_data <= rd_q;
                            m.m_sof  <= s1_sof;
                            m.m_eol  <= s1_eol;
                            m.m_eof  <= s1_eof;
                        end else begin
                            m.m_sof  <= 1'b0;
                            m.m_eol  <= 1'b0;
                            m.m_eof  <= 1'b0;
                        end
                    end
                    if (m.m_valid && m.m_ready && m.m_eof) begin
                        state      <= COLLECT;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_frame_sink.sv
// Bench for conv_frame_sink: a frame model built from the written pixels, checked on every handshake.
module tb_conv_frame_sink;
    localparam int W     = 50;
    localparam int H     = 50;
    localparam int DW    = 12;
    localparam int AW    = 17;
    localparam int TOTAL = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          conv_done = 1'b1;
    logic          busy, frame_done, err_oob, err_ovr, state_dbg;

    conv_frame_sink_if #(.DW(DW)) sif ();

    conv_frame_sink #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .conv_done  (conv_done),
        .m          (sif),
        .busy       (busy),
        .frame_done (frame_done),
        .err_oob    (err_oob),
        .err_ovr    (err_ovr),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [DW+2:0] exp_q[$];
    logic [DW-1:0] exp_mem [TOTAL];
    int fd_cnt = 0, fd_cyc = 0, n_cyc = 0, stall_cnt = 0, hs_cnt = 0, sof_cyc = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // model: one entry {eof, eol, sof, data} per raster position
    function automatic void build_frame();
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++)
            exp_q.push_back({1'(i == TOTAL - 1), 1'(i % W == W - 1), 1'(i == 0), exp_mem[i]});
    endfunction

    // driver tasks (all start and end 1 ns after a rising edge)
    task automatic write_px(input int a, input int d, input bit upd);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (upd && a < TOTAL) exp_mem[a] = DW'(d);
    endtask

    task automatic start_frame();
        build_frame();
        conv_done = 1'b1;
        @(posedge clk); #1;
        n_cyc = cyc; stall_cnt = 0; hs_cnt = 0;
        conv_done = 1'b0;
        check("busy_after_rise", busy, 1);
    endtask

    task automatic wait_frame(input string name);
        int start_fd = fd_cnt;
        int t = 0;
        while (fd_cnt == start_fd && t < 20000) begin
            @(posedge clk); #1; t++;
        end
        check({name, "_frame_done_seen"}, fd_cnt - start_fd, 1);
        check({name, "_len"}, fd_cyc - n_cyc, 2502 + stall_cnt);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_frame_done_once"}, fd_cnt - start_fd, 1);
        check({name, "_all_pixels"}, exp_q.size(), 0);
        check({name, "_busy_low"}, busy, 0);
    endtask

    initial begin
        sif.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            sif.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // scoreboard / compare process
    logic [DW+2:0] act_v, prev_act, exp_v;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            act_v = {sif.m_eof, sif.m_eol, sif.m_sof, sif.m_data};
            if (prev_stall) check("stall_hold", {sif.m_valid, act_v}, {1'b1, prev_act});
            if (sif.m_valid && sif.m_ready) begin
                check("pixel_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check("pixel", act_v, exp_v);
                end
                if (sif.m_sof) sof_cyc = cyc;
                hs_cnt++;
            end else if (sif.m_valid) begin
                stall_cnt++;
            end
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_act   = act_v;
        end
    end

    initial begin
        int t;
        int fd_before;
        #2;
        check("rst_m_valid", sif.m_valid, 0);
        check("rst_m_data", sif.m_data, 0);
        check("rst_markers", {sif.m_sof, sif.m_eol, sif.m_eof}, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_errs", {err_oob, err_ovr}, 0);
        check("rst_state", state_dbg, 0);

        // release reset with conv_done already high: nothing may start
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("held_done_no_busy", busy, 0);
        check("held_done_no_valid", sif.m_valid, 0);
        conv_done = 1'b0;

        for (int i = 0; i < TOTAL; i++) write_px(i, i % 4096, 1'b1);
        write_px(2500, 'hFFF, 1'b1);
        check("err_oob_first", err_oob, 1);
        write_px(2600, 'hFFF, 1'b1);
        check("err_oob_sticky", err_oob, 1);
        check("err_ovr_clear", err_ovr, 0);

        // full frame, no backpressure (also the low-to-high conv_done start)
        start_frame();
        check("model_px0", exp_q[0], {3'b001, 12'd0});
        check("model_px49", exp_q[49], {3'b010, 12'd49});
        check("model_px50", exp_q[50], {3'b000, 12'd50});
        check("model_px2499", exp_q[2499], {3'b110, 12'd2499});
        wait_frame("full");
        check("full_sof_latency", sof_cyc - n_cyc, 2);
        check("err_oob_kept", err_oob, 1);

        // random backpressure
        rand_ready = 1'b1;
        start_frame();
        wait_frame("bp");
        rand_ready = 1'b0;
        check("bp_stalls_seen", stall_cnt > 0, 1);

        // write during stream, then replay
        start_frame();
        @(posedge clk); #1;
        write_px(5, 'hABC, 1'b0);
        check("err_ovr_set", err_ovr, 1);
        wait_frame("ovr");
        start_frame();
        check("model_px5", exp_q[5], {3'b000, 12'd5});
        wait_frame("replay");
        check("err_ovr_kept", err_ovr, 1);

        // reset mid-stream
        start_frame();
        t = 0;
        while (hs_cnt < 1000 && t < 5000) begin
            @(negedge clk); t++;
        end
        check("reach_px1000", hs_cnt >= 1000, 1);
        fd_before = fd_cnt;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", sif.m_valid, 0);
        check("mid_rst_data", sif.m_data, 0);
        check("mid_rst_markers", {sif.m_sof, sif.m_eol, sif.m_eof}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_errs", {err_oob, err_ovr, frame_done}, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_fd_after_reset", fd_cnt, fd_before);
        check("idle_after_reset", {busy, sif.m_valid}, 0);
        start_frame();
        wait_frame("restart");
        check("restart_sof_latency", sof_cyc - n_cyc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_frame_sink.md
# conv_frame_sink

Downstream stage of `conv2d`. Captures the convolution result writes (`addr_wr`/`d_out`) into an internal frame buffer of IMG_W×IMG_H pixels. When `conv2d` signals completion on its `ready` output, the block replays the frame in raster order as a valid/ready pixel stream with line and frame markers. The stream feeds the next CFA stage or the bench's file dumper.

## Interface
Parameters:
- IMG_W, 50, frame width in pixels
- IMG_H, 50, frame height in pixels
- DW, 12, pixel width
- AW, 17, write address width; must match `conv2d` `addr_wr`

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- wr_en  in  1  write strobe qualifying wr_addr/wr_data
- wr_addr  in  AW  linear pixel index (y*IMG_W+x), from `conv2d` addr_wr
- wr_data  in  DW  result pixel, from `conv2d` d_out
- conv_done  in  1  `conv2d` ready; the rising edge ends the capture
- m_data  out  DW  streamed pixel
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts the pixel on clk edge when m_valid && m_ready
- m_sof  out  1  qualifies pixel index 0
- m_eol  out  1  qualifies the last pixel of each line (x == IMG_W-1)
- m_eof  out  1  qualifies pixel index IMG_W*IMG_H-1
- busy  out  1  high while in STREAM
- frame_done  out  1  one-cycle pulse after the last pixel handshake
- err_oob  out  1  sticky: an out-of-range write was dropped
- err_ovr  out  1  sticky: a write arrived during STREAM and was dropped

## Operation
- Frame buffer: IMG_W*IMG_H × DW, one synchronous write port and one synchronous read port (1-cycle read latency). It is not cleared by reset. Pixels that were never written stream out undefined.
- conv_done is registered once. `done_rise = conv_done & ~conv_done_q`.
- States:
  - COLLECT (reset state):
    - When wr_en=1 and wr_addr < IMG_W*IMG_H, write wr_data to the buffer.
    - When wr_en=1 and wr_addr ≥ IMG_W*IMG_H, drop the write and set err_oob.
    - On done_rise, go to STREAM. The read index resets to 0.
  - STREAM:
    - Read pixels in order 0..IMG_W*IMG_H-1 and present them on m_data.
    - Any wr_en=1 is dropped and sets err_ovr; the buffer is unchanged.
    - done_rise is ignored.
    - After the handshake of the pixel with m_eof=1, pulse frame_done and return to COLLECT.
- Markers m_sof, m_eol and m_eof are valid only with m_valid. They are computed from an x/y counter pair, not by division. x wraps at IMG_W-1 and increments y.
- Handshake rules:
  - While m_valid=1 && m_ready=0, m_data and all markers hold stable.
  - m_valid never deasserts without a handshake.
  - Reads are issued ahead (prefetch or skid register) so that one pixel transfers per cycle while m_ready is held high.
- err_oob and err_ovr clear only on reset.
- Simultaneous events:
  - A write and done_rise in the same cycle in COLLECT: the write is performed, and the state enters STREAM.
  - conv_done already high at reset release does not start a stream, because conv_done_q resets to 1. A low-to-high transition is required.

## Timing
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, m_eof=0, busy=0, frame_done=0, err_oob=0, err_ovr=0. State is COLLECT, conv_done_q=1, counters 0.
- Reset asserted mid-stream: all outputs above drop asynchronously. The stream is abandoned with no frame_done, and the buffer contents are retained.
- Write latency: a write at edge N is readable by a read issued at edge N+1 or later.
- done_rise is sampled at edge N:
  - busy=1 after N.
  - First m_valid=1, carrying pixel 0 with m_sof=1, after edge N+2.
- With m_ready held at 1: pixel k is presented after edge N+2+k. The last pixel (k=2499 by default) is accepted at edge N+2+2499+1. frame_done=1 for the cycle after that edge, and busy=0 from the same point.
- Stall: deasserting m_ready for S cycles extends the frame by exactly S cycles. There are no bubbles after m_ready returns.
- Minimum spacing between successive streams is one COLLECT cycle.

## Test plan
- Full frame, no backpressure:
  - Stimulus: write pixel i = i mod 4096 for i = 0..2499, then pulse conv_done.
  - Required: 2500 handshakes with data 0..2499 in order.
  - Markers: m_sof only on 0; m_eol on 49, 99, …, 2499; m_eof only on 2499.
  - Timing: frame_done exactly once, 2502 cycles after done_rise.
- Random backpressure:
  - Stimulus: same frame, m_ready driven by a 50% random pattern.
  - Required: identical data/marker sequence; m_data stable during every stall; frame length equals 2502 plus the number of stall cycles.
- Out-of-range write:
  - Stimulus: wr_addr=2500, then 2600, data 0xFFF, during COLLECT.
  - Required: err_oob=1 after the first write and stays 1; the streamed frame is unaffected.
- Write during STREAM:
  - Stimulus: wr_en=1, wr_addr=5, data 0xABC, two cycles after done_rise.
  - Required: err_ovr=1; pixel 5 in this frame and in a replayed second frame keeps its old value 5.
- Reset mid-stream:
  - Stimulus: assert rst=0 at pixel 1000, release, then give a new conv_done rising edge.
  - Required: outputs go to their reset values immediately and no frame_done occurs. The second stream restarts at pixel 0 with the original buffer data.
- conv_done held high across reset release:
  - Stimulus: release reset with conv_done=1.
  - Required: no stream starts. Dropping conv_done to 0 and raising it to 1 starts a stream.
